// File: rtl/alu_pkg.sv
// ALU opcode encodings shared by the ALU datapath and its arbiter, plus a small index-wrap helper.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_SLL   = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_SRL   = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SRA   = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'b1001;
  localparam logic [ALU_OP_W-1:0] ALU_PASSB = 4'b1101;

  // Callers never pass i >= 2*n, so one subtraction is enough.
  function automatic int wrap_idx(input int i, input int n);
    return (i >= n) ? i - n : i;
  endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational ALU: shifts use b[4:0], add/sub wrap, unlisted opcodes return zero.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [ALU_OP_W-1:0]   op,
  output logic [DATA_WIDTH-1:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_SLL:   result = a << shamt;
      ALU_SLT:   result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      ALU_XOR:   result = a ^ b;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $signed(a) >>> shamt;
      ALU_OR:    result = a | b;
      ALU_AND:   result = a & b;
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters (round-robin; fixed priority to index 0 when ALU_ARB_FIXED_PRIO_EN).
// One cycle from grant to a registered result; no grants while the result is held with resp_ready low.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REQ    = 2,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b,
  input  logic [NUM_REQ*ALU_OP_W-1:0]    req_op,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [DATA_WIDTH-1:0]          resp_data,
  output logic [ID_W-1:0]                resp_id
);

  logic                  can_issue;
  logic                  gnt_vld;
  logic [ID_W-1:0]       gnt_idx;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [ALU_OP_W-1:0]   alu_op;
  logic [DATA_WIDTH-1:0] alu_res;
  int                    start_idx;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign start_idx = 0;
`else
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] nxt_ptr;
  assign start_idx = int'(rr_ptr);
  assign nxt_ptr   = ID_W'(wrap_idx(int'(gnt_idx) + 1, NUM_REQ));
`endif

  // Output slot frees up either when empty or when it drains this same cycle.
  assign can_issue = !rst && (!resp_valid || resp_ready);

  // Scan from the far end so the requester closest to start_idx is written last and wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_idx(start_idx + k, NUM_REQ)]) begin
        gnt_vld = 1'b1;
        gnt_idx = ID_W'(wrap_idx(start_idx + k, NUM_REQ));
      end
    end
    gnt_vld = gnt_vld & can_issue;
  end

  assign req_ready = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;

  assign alu_a  = req_a[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign alu_b  = req_b[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign alu_op = req_op[int'(gnt_idx)*ALU_OP_W +: ALU_OP_W];

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_ptr     <= '0;
`endif
    end else if (gnt_vld) begin
      resp_valid <= 1'b1;
      resp_data  <= alu_res;
      resp_id    <= gnt_idx;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_ptr     <= nxt_ptr;
`endif
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then constrained-random traffic, all checked against a cycle model.
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int N  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N*4-1:0]  req_op;
  logic            resp_valid;
  logic            resp_ready;
  logic [DW-1:0]   resp_data;
  logic [0:0]      resp_id;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: buffered result and the requester that should be scanned first.
  logic        m_vld;
  logic [31:0] m_dat;
  int          m_id;
  int          m_ptr;
  bit          last_gv;
  int          last_g;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << sh;
      4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> sh;
      4'd7:  return $signed(a) >>> sh;
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd13: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 4))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    req_valid[i]        = v;
    req_a[i*DW +: DW]   = a;
    req_b[i*DW +: DW]   = b;
    req_op[i*4 +: 4]    = op;
  endtask

  // Called at a falling edge with inputs driven: checks outputs, advances one clock, returns at the next falling edge.
  task automatic tick();
    bit          gv;
    int          g;
    logic [31:0] res;
    #1;
    gv = 0;
    g  = 0;
    if (!rst && (!m_vld || resp_ready)) begin
      for (int k = 0; k < N; k++) begin
        if (!gv && req_valid[(m_ptr + k) % N]) begin
          gv = 1;
          g  = (m_ptr + k) % N;
        end
      end
    end
    chk("req_ready", req_ready, gv ? (64'd1 << g) : 64'd0);
    chk("resp_valid", resp_valid, m_vld);
    chk("resp_data", resp_data, m_dat);
    chk("resp_id", resp_id, m_id);
    res = ref_alu(req_a[g*DW +: DW], req_b[g*DW +: DW], req_op[g*4 +: 4]);
    @(posedge clk);
    if (rst) begin
      m_vld = 0; m_dat = 0; m_id = 0; m_ptr = 0;
    end else if (gv) begin
      m_vld = 1; m_dat = res; m_id = g;
`ifndef ALU_ARB_FIXED_PRIO_EN
      m_ptr = (g + 1) % N;
`endif
    end else if (resp_ready) begin
      m_vld = 0;
    end
    last_gv = gv;
    last_g  = gv ? g : -1;
    @(negedge clk);
  endtask

  logic [31:0] sa [5];
  logic [31:0] sb [5];
  logic [3:0]  sop[5];
  logic [31:0] sexp[5];
  logic [31:0] hold_dat;
  logic        hold_id;
  bit          pend;

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; resp_ready = 1'b0;
    m_vld = 0; m_dat = 0; m_id = 0; m_ptr = 0; last_gv = 0; last_g = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset holds off grants even with every requester asking.
    req_valid = '1;
    tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", resp_valid, 0);

    // Single add request.
    rst = 1'b0; resp_ready = 1'b1;
    set_req(0, 1, 32'd5, 32'd3, 4'b0000);
    set_req(1, 0, 32'd0, 32'd0, 4'b0000);
    tick();
    chk("add_valid", resp_valid, 1);
    chk("add_data", resp_data, 32'd8);
    chk("add_id", resp_id, 0);

    // Both requesters continuously valid: one response per cycle, alternating.
    set_req(0, 1, 32'd10, 32'd4, 4'b0001);
    set_req(1, 1, 32'h8000_0000, 32'd4, 4'b0111);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("alt_valid", resp_valid, 1);
      chk("alt_id", resp_id, (i % 2 == 0) ? 1 : 0);
      chk("alt_data", resp_data, (i % 2 == 0) ? 32'hF800_0000 : 32'd6);
    end

    // Backpressure: result held while requester 1 waits.
    hold_dat = resp_data; hold_id = resp_id;
    resp_ready = 1'b0;
    set_req(0, 0, 32'd0, 32'd0, 4'b0000);
    set_req(1, 1, 32'hFF, 32'h0F, 4'b0101);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_ready", req_ready, 0);
      chk("bp_data", resp_data, hold_dat);
      chk("bp_id", resp_id, hold_id);
      chk("bp_valid", resp_valid, 1);
    end
    resp_ready = 1'b1;
    tick();
    chk("refill_data", resp_data, 32'hF0);
    chk("refill_id", resp_id, 1);

    // Opcode corners through requester 0.
    set_req(1, 0, 32'd0, 32'd0, 4'b0000);
    sa[0] = 32'd1; sb[0] = 32'hFFFF_FFFF; sop[0] = 4'b0100; sexp[0] = 32'd1;
    sa[1] = 32'd1; sb[1] = 32'hFFFF_FFFF; sop[1] = 4'b0011; sexp[1] = 32'd0;
    sa[2] = 32'd1; sb[2] = 32'd33;        sop[2] = 4'b0010; sexp[2] = 32'd2;
    sa[3] = 32'd7; sb[3] = 32'h1234;      sop[3] = 4'b1101; sexp[3] = 32'h1234;
    sa[4] = 32'd7; sb[4] = 32'd9;         sop[4] = 4'b1111; sexp[4] = 32'd0;
    for (int i = 0; i < 5; i++) begin
      set_req(0, 1, sa[i], sb[i], sop[i]);
      tick();
      chk("op_data", resp_data, sexp[i]);
    end

    // Reset while FULL discards the result and restarts the scan at requester 0.
    set_req(0, 1, 32'd0, 32'h55, 4'b1101);
    tick();
    chk("pre_rst_data", resp_data, 32'h55);
    set_req(0, 0, 32'd0, 32'd0, 4'b0000);
    resp_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_full_valid", resp_valid, 0);
    chk("rst_full_data", resp_data, 0);
    chk("rst_full_id", resp_id, 0);
    rst = 1'b0; resp_ready = 1'b1;
    set_req(0, 1, 32'd2, 32'd3, 4'b0000);
    set_req(1, 1, 32'd6, 32'd3, 4'b1001);
    tick();
    chk("post_rst_id", resp_id, 0);
    chk("post_rst_data", resp_data, 32'd5);

    // Sustained contention: fixed priority starves 1, round-robin alternates.
    for (int i = 0; i < 10; i++) begin
      tick();
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("prio_id", resp_id, 0);
`else
      chk("fair_id", resp_id, (i % 2 == 0) ? 1 : 0);
`endif
    end
    set_req(0, 0, 32'd0, 32'd0, 4'b0000);
    tick();
    chk("req1_served", resp_id, 1);
    chk("req1_data", resp_data, 32'd2);

    // Random traffic obeying the hold-until-accepted rule.
    for (int c = 0; c < 400; c++) begin
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        pend = req_valid[i] && last_gv && (last_g != i);
        pend = pend || (req_valid[i] && !last_gv);
        if (!pend)
          set_req(i, $urandom_range(0, 2) != 0, rnd_word(), rnd_word(), 4'($urandom_range(0, 15)));
      end
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU between NUM_REQ independent requesters, e.g. a pipeline execute stage and a multi-cycle address/CSR sequencer.
- Arbitrates round-robin and issues one operation per cycle into the ALU.
- Captures the result in a single-entry output register, returned with the requester ID over a valid/ready response channel.
- Sits between issue logic and writeback.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- NUM_REQ, 2, number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ), width of the requester ID; derived, not to be overridden.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester grant/accept; at most one bit high.
- req_a  in  NUM_REQ*DATA_WIDTH  operand a; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_b  in  NUM_REQ*DATA_WIDTH  operand b; same slicing as req_a.
- req_op  in  NUM_REQ*4  4-bit ALU control per requester.
- resp_valid  out  1  result register holds a valid result.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  DATA_WIDTH  registered ALU result.
- resp_id  out  ID_W  index of the requester that produced resp_data.

Behaviour:
- Reset is synchronous, active-high, and is the only reset.
  - resp_valid=0, resp_data=0, resp_id=0, rr_ptr=0.
  - While rst=1, req_ready=0 for all requesters.
  - Reset mid-operation discards any buffered result; no response is emitted for it.
- Output buffer has two states:
  - EMPTY (resp_valid=0).
  - FULL (resp_valid=1).
- can_issue = !resp_valid || resp_ready. This allows a same-cycle drain and refill, sustaining 1 op/cycle.
- Arbitration, combinational:
  - When can_issue=1, grant the first requester with req_valid set, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[g]=1 only for the granted g. All req_ready are 0 when can_issue=0 or no request is pending.
  - req_ready never depends on req_valid of the same requester beyond the grant selection; no combinational path from resp_ready to req_a/req_b/req_op.
- Transfer on req_valid[g] && req_ready[g]:
  - The ALU computes on requester g's a, b and op.
  - Next edge: resp_data <= result, resp_id <= g, resp_valid <= 1, rr_ptr <= (g+1) mod NUM_REQ.
  - Latency is 1 cycle from acceptance to resp_valid.
- Drain without refill: when resp_valid && resp_ready and no grant, resp_valid <= 0. resp_data and resp_id hold their values.
- Backpressure (FULL and resp_ready=0):
  - resp_valid, resp_data and resp_id are stable.
  - No grants; rr_ptr holds.
- No pending requests: rr_ptr holds.
- Requesters must hold req_a, req_b and req_op stable while req_valid is high and not yet accepted. The block does not check this.
- ALU function is fixed, encoded on op:
  - 0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 sltu.
  - 0101 xor, 0110 srl, 0111 sra, 1000 or, 1001 and.
  - 1101 pass b.
  - All other encodings give 0.
  - Shifts use b[4:0]. Add and sub wrap modulo 2^DATA_WIDTH.
- Fairness: with all requesters continuously valid and resp_ready=1, the grant sequence is 0,1,...,NUM_REQ-1,0,...

Optional Feature:
- Macro ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_ptr is removed; the scan always starts at 0. Higher indices may starve; this is intended for a latency-critical requester 0.
- Undefined (default): round-robin as above.
- Ports and latency are identical in both builds.

Decomposition:
- Shared package alu_pkg:
  - ALU op localparams: ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB.
  - ALU_OP_W=4.
- Sub-module: instantiate the existing alu module as the datapath, fed by the muxed operands. The arbiter holds only the mux, grant logic, rr_ptr and output register.

Test Plan:
- Reset, then single request: req0 a=5, b=3, op=0000 -> req_ready[0]=1 same cycle; next cycle resp_valid=1, resp_data=8, resp_id=0.
- Both requesters valid continuously, resp_ready=1: req0 sub 10-4, req1 sra 0x80000000>>4 -> alternating responses 6 (id0), 0xF8000000 (id1), 6, ...; one response every cycle.
- Backpressure: result held with resp_ready=0 for 3 cycles while req1 is valid (xor 0xFF,0x0F) -> req_ready=0, resp_data/resp_id stable; on resp_ready=1 same-cycle refill gives 0xF0 with id1 the next cycle.
- Op coverage, single requester: sltu 1,0xFFFFFFFF -> 1; slt 1,0xFFFFFFFF -> 0; sll 1,b=33 -> 2; op 1101 b=0x1234 -> 0x1234; op 1111 -> 0.
- Reset asserted while FULL: resp_valid=1 with data 0x55 -> after the reset edge resp_valid=0, resp_data=0, resp_id=0, rr_ptr=0; next grant goes to requester 0 when both are valid.
- ALU_ARB_FIXED_PRIO_EN build, both valid, resp_ready=1 -> only id0 served for 10 cycles; after req0 deasserts, id1 is served next cycle.
